hog_frame_ctrl: RTL and testbench

Frame sequencer for the `binning` gradient/orientation pipeline. It admits exactly one frame of pixels into `binning` per `start` command and counts accepted gradient samples on the output side. It tags each sample with gradient row/column, cell coordinates and frame markers, and reports frame completion. It sits between the pixel source and `binning` on the input side, and taps the `binning` → histogram-accumulator handshake on the output side.

---
 rtl/hog_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_hog_frame_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hog_frame_ctrl.sv
// hog_frame_ctrl: admits one frame of pixels into binning per start and tags/counts its gradient samples
module hog_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMAGE_WIDTH = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int CELL_SIZE = 8,
  localparam int CW = $clog2(IMAGE_WIDTH),
  localparam int RW = $clog2(IMAGE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_overrun,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_pixel,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic [DATA_WIDTH-1:0] pixel,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic                  sink_valid,
  input  logic                  sink_ready,
  output logic [CW-1:0]         grad_col,
  output logic [RW-1:0]         grad_row,
  output logic [CW-1:0]         cell_x,
  output logic [RW-1:0]         cell_y,
  output logic                  cell_full,
  output logic                  sof,
  output logic                  eof
);
  localparam int GRAD_W = IMAGE_WIDTH - 2;
  localparam int GRAD_H = IMAGE_HEIGHT - 2;
  localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PW = $clog2(TOTAL);
  localparam int CS = $clog2(CELL_SIZE);
  localparam logic [PW-1:0] PIX_LAST = PW'(TOTAL - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(GRAD_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRAD_H - 1);
  localparam logic [CW-1:0] CELLS_X = CW'(GRAD_W / CELL_SIZE);
  localparam logic [RW-1:0] CELLS_Y = RW'(GRAD_H / CELL_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;
  logic [PW-1:0] pix_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic act, in_acc, out_acc, col_last, row_last, in_done, out_done;

  // handshake pass-through, gated only by registered state
  always_comb begin
    act = (state == RUN) || (state == DRAIN);
    busy = state != IDLE;
    frame_done = state == DONE;
    src_ready = (state == RUN) && pixel_ready;
    pixel_valid = (state == RUN) && src_valid;
    pixel = src_pixel;
    sink_valid = act && bin_valid;
    bin_ready = act ? sink_ready : 1'b1;
    in_acc = (state == RUN) && src_valid && pixel_ready;
    out_acc = act && bin_valid && sink_ready;
    col_last = col_q == COL_LAST;
    row_last = row_q == ROW_LAST;
    in_done = in_acc && (pix_q == PIX_LAST);
    out_done = out_acc && col_last && row_last;
  end

  // annotation of the sample currently presented, zero outside a frame
  always_comb begin
    grad_col = act ? col_q : '0;
    grad_row = act ? row_q : '0;
    cell_x = grad_col >> CS;
    cell_y = grad_row >> CS;
    cell_full = act && (cell_x < CELLS_X) && (cell_y < CELLS_Y);
    sof = act && (col_q == '0) && (row_q == '0);
    eof = act && col_last && row_last;
  end

  // next state: output completion wins, so a coincident input completion skips DRAIN
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == DONE ? IDLE :
              out_done ? DONE :
              (state == RUN && in_done) ? DRAIN : state;
  end

  // state, counters and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pix_q <= '0;
      col_q <= '0;
      row_q <= '0;
      frame_count <= '0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        pix_q <= '0;
        col_q <= '0;
        row_q <= '0;
        err_overrun <= 1'b0;
      end else if (state == IDLE && bin_valid) begin
        err_overrun <= 1'b1;
      end
      if (in_acc) pix_q <= pix_q + 1'b1;
      if (out_acc) begin
        col_q <= col_last ? '0 : col_q + 1'b1;
        row_q <= col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
      end
      if (state == DONE) frame_count <= frame_count + 1'b1;
    end
  end

  // binning can never finish a frame before it has seen every pixel
  assert property (@(posedge clk) disable iff (rst) !(state == RUN && out_done && !in_done));
endmodule

// File: tb/tb_hog_frame_ctrl.sv
// tb_hog_frame_ctrl: randomized directed bench against a frame-level reference model
module tb_hog_frame_ctrl;
  localparam int NP = 48;
  localparam int NS = 24;
  localparam int GW = 6;
  localparam int GH = 4;
  localparam int CSZ = 2;

  logic clk = 0, rst = 1, start = 0, src_valid = 0, pixel_ready = 0, bin_valid = 0, sink_ready = 0;
  logic [7:0] src_pixel = 0;
  logic busy, frame_done, err_overrun, src_ready, pixel_valid, bin_ready, sink_valid, cell_full, sof, eof;
  logic [15:0] frame_count;
  logic [7:0] pixel;
  logic [2:0] grad_col, grad_row, cell_x, cell_y;

  logic start9 = 0, bin_valid9 = 0;
  logic busy9, frame_done9, err_overrun9, src_ready9, pixel_valid9, bin_ready9, sink_valid9, cell_full9, sof9, eof9;
  logic [15:0] frame_count9;
  logic [7:0] pixel9;
  logic [3:0] grad_col9, cell_x9;
  logic [2:0] grad_row9, cell_y9;

  int checks = 0, errors = 0;
  bit m_act = 0, m_done = 0, m_err = 0;
  int pix = 0, smp = 0, fcnt = 0;

  always #5 clk = ~clk;

  hog_frame_ctrl #(.DATA_WIDTH(8), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(6), .CELL_SIZE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .err_overrun(err_overrun),
    .src_valid(src_valid), .src_ready(src_ready), .src_pixel(src_pixel),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel(pixel),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .grad_col(grad_col), .grad_row(grad_row), .cell_x(cell_x), .cell_y(cell_y),
    .cell_full(cell_full), .sof(sof), .eof(eof));

  hog_frame_ctrl #(.DATA_WIDTH(8), .IMAGE_WIDTH(9), .IMAGE_HEIGHT(6), .CELL_SIZE(2)) dut9 (
    .clk(clk), .rst(rst), .start(start9), .busy(busy9), .frame_done(frame_done9),
    .frame_count(frame_count9), .err_overrun(err_overrun9),
    .src_valid(src_valid), .src_ready(src_ready9), .src_pixel(src_pixel),
    .pixel_valid(pixel_valid9), .pixel_ready(pixel_ready), .pixel(pixel9),
    .bin_valid(bin_valid9), .bin_ready(bin_ready9), .sink_valid(sink_valid9), .sink_ready(sink_ready),
    .grad_col(grad_col9), .grad_row(grad_row9), .cell_x(cell_x9), .cell_y(cell_y9),
    .cell_full(cell_full9), .sof(sof9), .eof(eof9));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit run_in;
    int col, row;
    run_in = m_act && pix < NP;
    col = m_act ? smp % GW : 0;
    row = m_act ? smp / GW : 0;
    chk("busy", busy, m_act || m_done);
    chk("frame_done", frame_done, m_done);
    chk("frame_count", frame_count, fcnt);
    chk("err_overrun", err_overrun, m_err);
    chk("src_ready", src_ready, run_in && pixel_ready);
    chk("pixel_valid", pixel_valid, run_in && src_valid);
    if (run_in && src_valid) chk("pixel", pixel, src_pixel);
    chk("sink_valid", sink_valid, m_act && bin_valid);
    chk("bin_ready", bin_ready, m_act ? sink_ready : 1'b1);
    chk("grad_col", grad_col, col);
    chk("grad_row", grad_row, row);
    chk("cell_x", cell_x, col / CSZ);
    chk("cell_y", cell_y, row / CSZ);
    chk("cell_full", cell_full, m_act && (col / CSZ) < (GW / CSZ) && (row / CSZ) < (GH / CSZ));
    chk("sof", sof, m_act && smp == 0);
    chk("eof", eof, m_act && smp == NS - 1);
  endtask

  task automatic update();
    if (rst) begin
      m_act = 0; m_done = 0; m_err = 0; pix = 0; smp = 0; fcnt = 0;
    end else if (!m_act && !m_done) begin
      if (start) begin
        m_act = 1; m_err = 0; pix = 0; smp = 0;
      end else if (bin_valid) m_err = 1;
    end else if (m_done) begin
      m_done = 0;
      fcnt = (fcnt + 1) % 65536;
    end else begin
      if (pix < NP && src_valid && pixel_ready) pix++;
      if (bin_valid && sink_ready) begin
        smp++;
        if (smp == NS) begin
          m_act = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    check_all();
    if (m_act && smp == 13 && bin_valid) begin
      chk("s13_col", grad_col, 1);
      chk("s13_row", grad_row, 2);
      chk("s13_cx", cell_x, 0);
      chk("s13_cy", cell_y, 1);
      chk("s13_full", cell_full, 1);
    end
    update();
    @(negedge clk);
  endtask

  task automatic run_frame(input int sr_pct, input bit misuse, input int stop_pix);
    start = 1;
    step();
    start = 0;
    for (int n = 0; n < 3000 && (m_act || m_done) && !(stop_pix > 0 && pix >= stop_pix); n++) begin
      src_valid = $urandom % 4 != 0;
      pixel_ready = $urandom % 4 != 0;
      src_pixel = 8'($urandom);
      sink_ready = $urandom_range(99) < sr_pct;
      bin_valid = (pix - smp > NP - NS) && ($urandom % 4 != 0);
      start = misuse && (m_done || $urandom % 5 == 0);
      step();
    end
    start = 0;
    bin_valid = 0;
    if (stop_pix == 0) chk("frame_timeout", busy, 0);
  endtask

  initial begin
    int p9, s9;
    @(negedge clk);
    step();
    step();
    rst = 0;
    step();
    run_frame(100, 0, 0);
    run_frame(30, 1, 0);
    run_frame(30, 1, 0);
    chk("fc_three", frame_count, 3);
    bin_valid = 1;
    repeat (3) step();
    bin_valid = 0;
    repeat (2) step();
    run_frame(100, 0, 0);
    run_frame(70, 0, 20);
    rst = 1;
    #1;
    update();
    check_all();
    step();
    rst = 0;
    step();
    run_frame(100, 0, 0);
    chk("fc_after_reset", frame_count, 1);
    p9 = 0;
    s9 = 0;
    src_valid = 1;
    pixel_ready = 1;
    sink_ready = 1;
    start9 = 1;
    @(negedge clk);
    start9 = 0;
    for (int n = 0; n < 300 && s9 < 28; n++) begin
      bin_valid9 = p9 - s9 > 26;
      #1;
      if (bin_valid9) begin
        chk("c9_col", grad_col9, s9 % 7);
        chk("c9_full", cell_full9, (s9 % 7) / 2 < 3);
        s9++;
      end
      if (p9 < 54) p9++;
      @(negedge clk);
    end
    bin_valid9 = 0;
    #1;
    chk("c9_done", frame_done9, 1);
    @(negedge clk);
    #1;
    chk("c9_count", frame_count9, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
